// File: rtl/npu_ahb_img_loader_if.sv
// AHB-Lite bus bundle between the image loader (master)
// and the NPU slave port.
interface npu_ahb_img_loader_if;
  logic [31:0] haddr_o;
  logic [1:0]  htrans_o;
  logic        hwrite_o;
  logic [2:0]  hsize_o;
  logic [2:0]  hburst_o;
  logic [3:0]  hprot_o;
  logic        hmastlock_o;
  logic [31:0] hwdata_o;
  logic        hready_i;
  logic        hresp_i;
  logic [31:0] hrdata_i;

  modport master (
    output haddr_o, htrans_o, hwrite_o, hsize_o,
    output hburst_o, hprot_o, hmastlock_o, hwdata_o,
    input  hready_i, hresp_i, hrdata_i
  );

  modport slave (
    input  haddr_o, htrans_o, hwrite_o, hsize_o,
    input  hburst_o, hprot_o, hmastlock_o, hwdata_o,
    output hready_i, hresp_i, hrdata_i
  );
endinterface

// File: rtl/npu_ahb_img_loader.sv
// AHB-Lite initiator: loads an image into the NPU,
// pulses write_row per row, polls done and reads the class.
module npu_ahb_img_loader #(
  parameter int          ROW_LEN   = 32,
  parameter int          NUM_ROWS  = 32,
  parameter logic [5:0]  THRESH    = 6'd4,
  parameter logic [31:0] CSR_BASE  = 32'h8000_0000,
  parameter logic [31:0] STAT_BASE = 32'h8000_1000,
  parameter logic [31:0] MEM_BASE  = 32'h8000_2000,
  parameter int          POLL_GAP  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pix_valid,
  input  logic [7:0] pix_data,
  output logic       pix_ready,
  output logic       busy,
  output logic       done,
  output logic [4:0] class_o,
  output logic       err,
  npu_ahb_img_loader_if.master ahb
);
  localparam logic [1:0] HT_IDLE = 2'b00;
  localparam logic [1:0] HT_NSEQ = 2'b10;
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);
  localparam logic [11:0] COL_LAST = 12'(ROW_LEN - 1);
  localparam logic [5:0]  ROWS     = 6'(NUM_ROWS);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_PIX_W, S_GAP, S_DONE, S_ERR
  } state_t;

  typedef enum logic [2:0] {
    OP_CFG, OP_PIX, OP_ROW, OP_POLL, OP_CLS
  } op_t;

  state_t      state;
  op_t         op;
  logic [31:0] haddr_q;
  logic [1:0]  htrans_q;
  logic        hwrite_q;
  logic [31:0] hwdata_q;
  logic [11:0] pix_idx;
  logic [11:0] col;
  logic [5:0]  row_cnt;
  logic [GW-1:0] gap;
  logic        unused_rdata;

  assign ahb.haddr_o     = haddr_q;
  assign ahb.htrans_o    = htrans_q;
  assign ahb.hwrite_o    = hwrite_q;
  assign ahb.hwdata_o    = hwdata_q;
  assign ahb.hsize_o     = 3'b000;
  assign ahb.hburst_o    = 3'b000;
  assign ahb.hprot_o     = 4'b0011;
  assign ahb.hmastlock_o = 1'b0;
  assign unused_rdata    = ^ahb.hrdata_i[31:5];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op        <= OP_CFG;
      haddr_q   <= '0;
      htrans_q  <= HT_IDLE;
      hwrite_q  <= 1'b0;
      hwdata_q  <= '0;
      pix_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      class_o   <= '0;
      pix_idx   <= '0;
      col       <= '0;
      row_cnt   <= '0;
      gap       <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state    <= S_ADDR;
            op       <= OP_CFG;
            haddr_q  <= CSR_BASE + 32'h4;
            htrans_q <= HT_NSEQ;
            hwrite_q <= 1'b1;
            hwdata_q <= {4{2'b00, THRESH}};
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            pix_idx  <= '0;
            col      <= '0;
            row_cnt  <= '0;
          end
        end
        S_ADDR: begin
          if (ahb.hready_i) begin
            htrans_q <= HT_IDLE;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (ahb.hready_i && ahb.hresp_i) begin
            state <= S_ERR;
            err   <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else if (ahb.hready_i) begin
            unique case (op)
              OP_CFG: begin
                state     <= S_PIX_W;
                pix_ready <= 1'b1;
              end
              OP_PIX: begin
                pix_idx <= pix_idx + 12'd1;
                if (col == COL_LAST) begin
                  col      <= '0;
                  op       <= OP_ROW;
                  state    <= S_ADDR;
                  haddr_q  <= CSR_BASE;
                  htrans_q <= HT_NSEQ;
                  hwrite_q <= 1'b1;
                  hwdata_q <= 32'h1;
                end else begin
                  col       <= col + 12'd1;
                  state     <= S_PIX_W;
                  pix_ready <= 1'b1;
                end
              end
              OP_ROW: begin
                row_cnt <= row_cnt + 6'd1;
                if (row_cnt + 6'd1 == ROWS) begin
                  state <= S_GAP;
                  gap   <= '0;
                end else begin
                  state     <= S_PIX_W;
                  pix_ready <= 1'b1;
                end
              end
              OP_POLL: begin
                if (ahb.hrdata_i[0]) begin
                  op       <= OP_CLS;
                  state    <= S_ADDR;
                  haddr_q  <= STAT_BASE + 32'h4;
                  htrans_q <= HT_NSEQ;
                  hwrite_q <= 1'b0;
                  hwdata_q <= '0;
                end else begin
                  state <= S_GAP;
                  gap   <= '0;
                end
              end
              OP_CLS: begin
                class_o <= ahb.hrdata_i[4:0];
                done    <= 1'b1;
                busy    <= 1'b0;
                state   <= S_DONE;
              end
              default: state <= S_IDLE;
            endcase
          end
        end
        S_PIX_W: begin
          if (pix_valid) begin
            pix_ready <= 1'b0;
            op        <= OP_PIX;
            state     <= S_ADDR;
            haddr_q   <= MEM_BASE + {20'd0, pix_idx};
            htrans_q  <= HT_NSEQ;
            hwrite_q  <= 1'b1;
            hwdata_q  <= {4{pix_data}};
          end
        end
        S_GAP: begin
          if (gap == GAP_LAST) begin
            op       <= OP_POLL;
            state    <= S_ADDR;
            haddr_q  <= STAT_BASE;
            htrans_q <= HT_NSEQ;
            hwrite_q <= 1'b0;
            hwdata_q <= '0;
          end else begin
            gap <= gap + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_npu_ahb_img_loader.sv
// Bench for npu_ahb_img_loader: behavioural AHB slave, pixel feeder,
// table of load scenarios plus reset, stall, error and mid-op reset sequences.
module tb_npu_ahb_img_loader;
  localparam int ROW_LEN  = 4;
  localparam int NUM_ROWS = 2;
  localparam int POLL_GAP = 4;
  localparam int NPIX     = ROW_LEN * NUM_ROWS;
  localparam logic [5:0]  THRESH = 6'd3;
  localparam logic [31:0] CSR  = 32'h8000_0000;
  localparam logic [31:0] STAT = 32'h8000_1000;
  localparam logic [31:0] MEM  = 32'h8000_2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_data = 8'h00;
  logic       pix_ready, busy, done, err;
  logic [4:0] class_o;

  npu_ahb_img_loader_if bus();

  npu_ahb_img_loader #(
    .ROW_LEN(ROW_LEN), .NUM_ROWS(NUM_ROWS), .THRESH(THRESH),
    .CSR_BASE(CSR), .STAT_BASE(STAT), .MEM_BASE(MEM),
    .POLL_GAP(POLL_GAP)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .busy(busy), .done(done),
    .class_o(class_o), .err(err), .ahb(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit is_mem(input logic [31:0] a);
    return (a >= MEM) && (a < MEM + 32'h1000);
  endfunction

  // ---------------- AHB slave model ----------------
  int          wr_wait = 1;
  int          err_at = -1;
  logic [4:0]  cls_val = 5'd0;
  bit          poll_q[$];
  bit          dph = 1'b0;
  logic [31:0] d_addr;
  bit          d_wr;
  int          wait_left;
  int          pix_wr_cnt = 0;
  int          stall_left = 0;
  int          stall_edges = 0;
  int          stall_bad = 0;
  logic [31:0] stall_addr;
  int          acc_cnt = 0;
  logic [31:0] wlog_a[$], wlog_d[$], rlog_a[$];
  int          rlog_c[$];
  bit          rsp;
  logic [31:0] rd;

  always @(posedge clk) begin
    rsp = 1'b0;
    cyc++;
    if (rst) begin
      dph = 1'b0;
      bus.hready_i <= 1'b1;
      bus.hresp_i  <= 1'b0;
    end else if (dph) begin
      if (bus.hready_i) begin
        dph = 1'b0;
        bus.hresp_i <= 1'b0;
        if (d_wr && !bus.hresp_i) begin
          wlog_a.push_back(d_addr);
          wlog_d.push_back(bus.hwdata_o);
        end
        if (d_wr && is_mem(d_addr)) pix_wr_cnt++;
      end else if (wait_left > 1) begin
        wait_left--;
      end else begin
        rsp = 1'b1;
      end
    end else if (stall_left > 0) begin
      if (bus.htrans_o == 2'b10 && !bus.hready_i) begin
        if (stall_edges == 0) stall_addr = bus.haddr_o;
        else if (bus.haddr_o !== stall_addr || !bus.hwrite_o) stall_bad++;
        stall_edges++;
        stall_left--;
      end
      bus.hready_i <= (stall_left == 0);
    end else if (bus.hready_i && bus.htrans_o == 2'b10) begin
      dph = 1'b1;
      d_addr = bus.haddr_o;
      d_wr = bus.hwrite_o;
      acc_cnt++;
      if (!d_wr) begin
        rlog_a.push_back(d_addr);
        rlog_c.push_back(cyc);
      end
      wait_left = d_wr ? wr_wait : 0;
      if (wait_left == 0) rsp = 1'b1;
      else bus.hready_i <= 1'b0;
    end
    if (rsp) begin
      rd = $urandom;
      if (!d_wr && d_addr == STAT)
        rd[0] = (poll_q.size() > 0) ? poll_q.pop_front() : 1'b1;
      if (!d_wr && d_addr == STAT + 32'h4) rd[4:0] = cls_val;
      bus.hready_i <= 1'b1;
      bus.hresp_i  <= d_wr && is_mem(d_addr) && (pix_wr_cnt == err_at);
      bus.hrdata_i <= rd;
    end
  end

  // ---------------- pixel source ----------------
  logic [7:0] pix_q[$];
  int fed = 0;
  int prob = 100;
  bit feed_en = 1'b0;
  bit pause = 1'b0;
  bit fire;

  initial forever begin
    @(negedge clk);
    fire = pix_valid && pix_ready;
    @(posedge clk);
    #1;
    if (fire) fed++;
    if (feed_en && !pause && fed < pix_q.size() &&
        $urandom_range(99) < prob) begin
      pix_valid = 1'b1;
      pix_data  = pix_q[fed];
    end else begin
      pix_valid = 1'b0;
      pix_data  = 8'($urandom);
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] exp_a[$], exp_d[$];

  function automatic void build_exp();
    exp_a.delete();
    exp_d.delete();
    exp_a.push_back(CSR + 32'h4);
    exp_d.push_back({4{2'b00, THRESH}});
    for (int k = 0; k < NPIX; k++) begin
      exp_a.push_back(MEM + k);
      exp_d.push_back({4{pix_q[k]}});
      if ((k + 1) % ROW_LEN == 0) begin
        exp_a.push_back(CSR);
        exp_d.push_back(32'h1);
      end
    end
  endfunction

  task automatic check_writes(input string tag);
    build_exp();
    chk({tag, "_nwr"}, wlog_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < wlog_a.size(); i++) begin
      chk($sformatf("%s_wr%0d_addr", tag, i), wlog_a[i], exp_a[i]);
      chk($sformatf("%s_wr%0d_data", tag, i), wlog_d[i], exp_d[i]);
    end
  endtask

  task automatic begin_load(input int ww, input int pr, input int n0,
                            input int cls, input bit fixed, input int ea);
    wr_wait = ww;
    prob = pr;
    err_at = ea;
    cls_val = 5'(cls);
    poll_q.delete();
    repeat (n0) poll_q.push_back(1'b0);
    poll_q.push_back(1'b1);
    pix_q.delete();
    for (int k = 0; k < NPIX; k++)
      pix_q.push_back(fixed ? 8'(8'h10 + k) : 8'($urandom));
    wlog_a.delete();
    wlog_d.delete();
    rlog_a.delete();
    rlog_c.delete();
    pix_wr_cnt = 0;
    fed = 0;
    pause = 1'b0;
    feed_en = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(done || err) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, n < 5000, 1);
  endtask

  typedef struct {
    bit fixed;
    int ww;
    int pr;
    int n0;
    int cls;
    int exp_polls;
    int exp_class;
  } vec_t;

  vec_t tbl[4];
  int a0;
  int n;

  initial begin
    tbl[0] = '{1'b1, 1, 100, 2, 19, 3, 19};
    tbl[1] = '{1'b0, 0, 50, 0, 7, 1, 7};
    tbl[2] = '{1'b0, 3, 30, 4, 31, 5, 31};
    tbl[3] = '{1'b0, 2, 80, 1, 0, 2, 0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_haddr", bus.haddr_o, 0);
    chk("rst_htrans", bus.htrans_o, 0);
    chk("rst_hwrite", bus.hwrite_o, 0);
    chk("rst_hwdata", bus.hwdata_o, 0);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_class", class_o, 0);
    chk("hsize", bus.hsize_o, 3'b000);
    chk("hburst", bus.hburst_o, 3'b000);
    chk("hprot", bus.hprot_o, 4'b0011);
    chk("hmastlock", bus.hmastlock_o, 0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_htrans", bus.htrans_o, 0);
    chk("idle_busy", busy, 0);

    // scenario table: full loads with varied timing and poll results
    for (int i = 0; i < 4; i++) begin
      string t;
      t = $sformatf("v%0d", i);
      begin_load(tbl[i].ww, tbl[i].pr, tbl[i].n0, tbl[i].cls,
                 tbl[i].fixed, -1);
      wait_end(t);
      check_writes(t);
      chk({t, "_nrd"}, rlog_a.size(), tbl[i].exp_polls + 1);
      for (int j = 0; j < rlog_a.size(); j++)
        chk($sformatf("%s_rd%0d_addr", t, j), rlog_a[j],
            (j < tbl[i].exp_polls) ? STAT : STAT + 32'h4);
      for (int j = 1; j < tbl[i].exp_polls && j < rlog_c.size(); j++)
        chk($sformatf("%s_pollgap%0d", t, j),
            (rlog_c[j] - rlog_c[j-1] - 1) >= POLL_GAP, 1);
      chk({t, "_class"}, class_o, tbl[i].exp_class);
      chk({t, "_done"}, done, 1);
      chk({t, "_busy"}, busy, 0);
      chk({t, "_err"}, err, 0);
    end

    // address-phase stall, random pix_valid, start while busy
    begin_load(1, 60, 0, 9, 1'b0, -1);
    n = 0;
    while (fed < 2 && n < 500) begin @(negedge clk); n++; end
    pause = 1'b1;
    while (!(pix_ready && !pix_valid) && n < 1000) begin
      @(negedge clk); n++;
    end
    chk("stall_reach_pixw", n < 1000, 1);
    stall_edges = 0;
    stall_bad = 0;
    stall_left = 5;
    repeat (2) @(posedge clk);
    #1 pause = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_end("stall");
    chk("stall_edges", stall_edges, 5);
    chk("stall_stable", stall_bad, 0);
    check_writes("stall");
    chk("stall_class", class_o, 9);
    chk("stall_done", done, 1);

    // error on third pixel write
    begin_load(1, 100, 0, 4, 1'b0, 2);
    wait_end("err");
    chk("err_flag", err, 1);
    chk("err_busy", busy, 0);
    chk("err_done", done, 0);
    chk("err_nwr", wlog_a.size(), 3);
    if (wlog_a.size() >= 3) begin
      chk("err_wr0", wlog_a[0], CSR + 32'h4);
      chk("err_wr1", wlog_a[1], MEM);
      chk("err_wr2", wlog_a[2], MEM + 32'h1);
    end
    a0 = acc_cnt;
    repeat (20) @(negedge clk);
    chk("err_no_nonseq", acc_cnt, a0);
    chk("err_htrans", bus.htrans_o, 0);
    begin_load(1, 100, 0, 4, 1'b0, -1);
    chk("err_cleared", err, 0);
    chk("err_restart_busy", busy, 1);
    wait_end("err_re");
    check_writes("err_re");
    chk("err_re_class", class_o, 4);

    // synchronous reset during a stalled pixel data phase
    begin_load(6, 100, 0, 2, 1'b0, -1);
    n = 0;
    while (!(dph && d_wr && is_mem(d_addr) && !bus.hready_i) && n < 500) begin
      @(negedge clk); n++;
    end
    chk("mid_reach_pixd", n < 500, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_htrans", bus.htrans_o, 0);
    chk("mid_busy", busy, 0);
    chk("mid_haddr", bus.haddr_o, 0);
    chk("mid_pix_ready", pix_ready, 0);
    chk("mid_hwrite", bus.hwrite_o, 0);
    rst = 1'b0;
    feed_en = 1'b0;
    repeat (2) @(posedge clk);
    begin_load(1, 100, 0, 21, 1'b0, -1);
    wait_end("mid_re");
    check_writes("mid_re");
    chk("mid_re_class", class_o, 21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
